// File: rtl/gardner_ted_pam_core.sv
// Gardner timing-error detector for a real PAM stream: e = (s[0] - s[N]) * s[N/2] on trigger.
// Optional GARDNER_TED_TRIGGER_HOLD_EN keeps a trigger that arrives while the output is busy.
module gardner_ted_pam_core #(
  parameter int SamplesPerSymbol = 4,
  parameter int InputLengthBits  = 12,
  parameter int OutputLengthBits = 25
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [InputLengthBits-1:0]  in,
  input  logic                        in_valid,
  input  logic                        trigger,
  output logic [OutputLengthBits-1:0] out,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int N  = SamplesPerSymbol;
  localparam int IL = InputLengthBits;
  localparam int OL = OutputLengthBits;
  localparam int DW = IL + 1;
  localparam int PW = 1 + 2 * IL;

  if ((N % 2) != 0 || N < 2) begin : g_bad_sps
    $error("SamplesPerSymbol must be even and >= 2");
  end
  if (OL < PW) begin : g_bad_olb
    $error("OutputLengthBits must be >= 1+2*InputLengthBits");
  end

  logic signed [IL-1:0] win_q [0:N];
  logic signed [IL-1:0] win_d [0:N];
  logic signed [DW-1:0] diff_s;
  logic signed [PW-1:0] prod_s;
  logic signed [OL-1:0] err_s;
  logic [OL-1:0]        out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 stage_free_s;
  logic                 take_s;

  // Sample window shift: newest sample enters at index 0.
  always_comb begin
    for (int k = 0; k <= N; k++) begin
      win_d[k] = win_q[k];
    end
    if (in_valid) begin
      for (int k = 1; k <= N; k++) begin
        win_d[k] = win_q[k-1];
      end
      win_d[0] = $signed(in);
    end else begin
      for (int k = 0; k <= N; k++) begin
        win_d[k] = win_q[k];
      end
    end
  end

  // Error term from the window as registered before this cycle's shift.
  always_comb begin
    diff_s = DW'(win_q[0]) - DW'(win_q[N]);
    prod_s = PW'(diff_s) * PW'(win_q[N/2]);
    err_s  = OL'(prod_s);
  end

  assign stage_free_s = ~out_valid_q | out_ready;

`ifdef GARDNER_TED_TRIGGER_HOLD_EN
  logic pend_q, pend_d;

  assign take_s = trigger | pend_q;

  // Pending-trigger flag: set by a trigger that meets a busy stage, cleared once loaded.
  always_comb begin
    pend_d = pend_q;
    if (stage_free_s) begin
      pend_d = 1'b0;
    end else if (trigger) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Pending-flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  assign take_s = trigger;
`endif

  // Output stage: load on a take when free, drop valid on acceptance, otherwise hold.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (stage_free_s) begin
      if (take_s) begin
        out_d       = err_s;
        out_valid_d = 1'b1;
      end else begin
        out_d       = out_q;
        out_valid_d = 1'b0;
      end
    end else begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= N; k++) begin
        win_q[k] <= '0;
      end
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k <= N; k++) begin
        win_q[k] <= win_d[k];
      end
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_gardner_ted_pam_core.sv
// Self-checking bench for gardner_ted_pam_core (N=4, 12-bit in, 25-bit out).
// The reference keeps the full sample history and the output-handshake rules in plain integers.
module tb_gardner_ted_pam_core;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] in = 12'd0;
  logic        in_valid = 1'b0;
  logic        trigger = 1'b0;
  logic [24:0] out;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  int hist[$];
  int m_out = 0;
  bit m_valid = 1'b0;
  bit m_pend = 1'b0;

  gardner_ted_pam_core #(
    .SamplesPerSymbol(4), .InputLengthBits(12), .OutputLengthBits(25)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .trigger(trigger),
    .out(out), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // k-th newest sample received since reset; zero before it arrives.
  function automatic int w(input int k);
    if (k < hist.size()) return hist[hist.size() - 1 - k];
    return 0;
  endfunction

  function automatic int model_err();
    return (w(0) - w(N)) * w(N / 2);
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(4095)) - 2048;
  endfunction

  // Apply one cycle of inputs, advance the reference, and land 1 time unit after the edge.
  task automatic step(input bit iv, input int x, input bit tg, input bit rd);
    bit free, take;
    int e;
    in_valid  = iv;
    in        = x[11:0];
    trigger   = tg;
    out_ready = rd;
    e    = model_err();
    free = !m_valid || rd;
`ifdef GARDNER_TED_TRIGGER_HOLD_EN
    take = tg || m_pend;
`else
    take = tg;
`endif
    if (free) begin
      m_pend = 1'b0;
      if (take) begin
        m_out   = e;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end else if (tg) begin
      m_pend = 1'b1;
    end
    if (iv) hist.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    hist.delete();
    m_out   = 0;
    m_valid = 1'b0;
    m_pend  = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 25'd0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%0b out=%0d, want 0/0", out_valid, $signed(out));
    end
    rst = 1'b0;
    step(1, 5, 0, 1); step(1, 0, 0, 1); step(1, 9, 0, 1); step(1, 0, 0, 1); step(1, -5, 0, 1);
    step(0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || $signed(out) !== -25'sd90) begin
      errors++;
      $display("FAIL pre_reset_out: out_valid=%0b out=%0d, want 1/-90", out_valid, $signed(out));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 25'd0) begin
      errors++;
      $display("FAIL async_reset: out_valid=%0b out=%0d, want 0/0", out_valid, $signed(out));
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step(0, 0, 1, 1);
    checks++;
    if (out_valid !== 1'b1 || out !== 25'd0) begin
      errors++;
      $display("FAIL zero_window: out_valid=%0b out=%0d, want 1/0", out_valid, $signed(out));
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_basic();
    int xs[5] = '{-100, 7, 10, 3, 100};
    foreach (xs[i]) step(1, xs[i], 0, 1);
    step(0, 0, 1, 1);
    checks++;
    if (out_valid !== 1'b1 || $signed(out) !== 25'sd2000 || m_out != 2000) begin
      errors++;
      $display("FAIL basic: out_valid=%0b out=%0d, want 1/2000", out_valid, $signed(out));
    end
    step(0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || $signed(out) !== 25'sd2000) begin
      errors++;
      $display("FAIL basic_accept: out_valid=%0b out=%0d, want 0/2000", out_valid, $signed(out));
    end
  endtask

  task automatic test_extremes();
    int a[5] = '{-2048, 0, -2048, 0, 2047};
    int b[5] = '{2047, 0, -2048, 0, -2048};
    foreach (a[i]) step(1, a[i], 0, 1);
    step(0, 0, 1, 1);
    checks++;
    if (out_valid !== 1'b1 || $signed(out) !== -25'sd8386560) begin
      errors++;
      $display("FAIL extreme_neg: out=%0d, want -8386560", $signed(out));
    end
    foreach (b[i]) step(1, b[i], 0, 1);
    step(0, 0, 1, 1);
    checks++;
    if (out_valid !== 1'b1 || $signed(out) !== 25'sd8386560) begin
      errors++;
      $display("FAIL extreme_pos: out=%0d, want 8386560", $signed(out));
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    int first;
    for (int i = 0; i < 5; i++) step(1, 11 * i - 20, 0, 1);
    step(0, 0, 1, 0);
    first = m_out;
    step(1, 333, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || $signed(out) !== 25'(first)) begin
      errors++;
      $display("FAIL bp_hold: out_valid=%0b out=%0d, want 1/%0d", out_valid, $signed(out), first);
    end
    step(0, 0, 0, 1);
    checks++;
    if (out_valid !== m_valid || out !== 25'(m_out)) begin
      errors++;
      $display("FAIL bp_release: out_valid=%0b out=%0d, want %0b/%0d",
               out_valid, $signed(out), m_valid, m_out);
    end
    step(0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_single: out_valid=%0b, want 0", out_valid);
    end
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(1), rnd_sample(), $urandom_range(2) == 0, $urandom_range(1));
      checks++;
      if (out_valid !== m_valid || out !== 25'(m_out)) begin
        errors++;
        $display("FAIL bp_random[%0d]: out_valid=%0b out=%0d, want %0b/%0d",
                 i, out_valid, $signed(out), m_valid, m_out);
      end
    end
    step(0, 0, 0, 1); step(0, 0, 0, 1);
  endtask

  task automatic test_same_cycle();
    for (int i = 1; i <= 5; i++) step(1, i, 0, 1);
    step(1, 50, 1, 1);
    checks++;
    if (out_valid !== 1'b1 || $signed(out) !== 25'sd12) begin
      errors++;
      $display("FAIL same_cycle: out=%0d, want 12", $signed(out));
    end
    step(0, 0, 1, 1);
    checks++;
    if (out_valid !== 1'b1 || $signed(out) !== 25'sd192) begin
      errors++;
      $display("FAIL back_to_back: out=%0d, want 192", $signed(out));
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_streaming();
    int n_iv = 0, n_trig = 0, n_pulse = 0;
    bit iv, tg;
    for (int i = 0; i < 400; i++) begin
      iv = ($urandom_range(3) != 0);
      tg = 1'b0;
      if (iv) begin
        n_iv++;
        if (n_iv % 4 == 0) begin
          tg = 1'b1;
          n_trig++;
        end
      end
      step(iv, rnd_sample(), tg, 1);
      if (out_valid === 1'b1) n_pulse++;
      checks++;
      if (out_valid !== m_valid || out !== 25'(m_out)) begin
        errors++;
        $display("FAIL stream[%0d]: out_valid=%0b out=%0d, want %0b/%0d",
                 i, out_valid, $signed(out), m_valid, m_out);
      end
    end
    step(0, 0, 0, 1);
    checks++;
    if (n_pulse != n_trig || n_trig == 0) begin
      errors++;
      $display("FAIL stream_pulses: pulses=%0d, want %0d", n_pulse, n_trig);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_same_cycle();
    test_streaming();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
